// File: rtl/fir_pkg.sv
// Shared widths, saturation limits and FSM state encoding for the FIR MAC engine.
package fir_pkg;

    localparam int NUM_TAPS = 1021;
    localparam int DATA_W   = 16;
    localparam int COEFF_W  = 16;
    localparam int ACC_W    = DATA_W + COEFF_W + 10;
    localparam int SHIFT    = 15;
    localparam int ADDR_W   = 10;
    localparam int SAT_MAX  = 32767;
    localparam int SAT_MIN  = -32768;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUTPUT
    } state_t;

endpackage

// File: rtl/fir_mac_engine_if.sv
// Queue, coefficient ROM and filtered-sample signals of the FIR MAC engine.
interface fir_mac_engine_if;
    import fir_pkg::*;

    logic                      sequencing;
    logic                      q_full;
    logic signed [DATA_W-1:0]  smpl_in;
    logic [ADDR_W-1:0]         coeff_addr;
    logic signed [COEFF_W-1:0] coeff;
    logic signed [DATA_W-1:0]  smpl_out;
    logic                      smpl_valid;
    logic                      len_err;
    logic                      seq_err;

    // master is the surrounding system (queue, ROM, CODEC path); slave is the engine.
    modport master (
        output sequencing, q_full, smpl_in, coeff,
        input  coeff_addr, smpl_out, smpl_valid, len_err, seq_err
    );

    modport slave (
        input  sequencing, q_full, smpl_in, coeff,
        output coeff_addr, smpl_out, smpl_valid, len_err, seq_err
    );

endinterface

// File: rtl/fir_round_sat.sv
// Rounds half-up, arithmetically shifts and saturates the accumulator to one output sample.
module fir_round_sat
    import fir_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] sat_out
);

    localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] MAX_A      = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] MIN_A      = ACC_W'(SAT_MIN);

    logic signed [ACC_W-1:0] rounded;

    always_comb begin
        rounded = (acc + ROUND_BIAS) >>> SHIFT;
        if (rounded > MAX_A) begin
            sat_out = DATA_W'(SAT_MAX);
        end else if (rounded < MIN_A) begin
            sat_out = DATA_W'(SAT_MIN);
        end else begin
            sat_out = DATA_W'(rounded);
        end
    end

endmodule

// File: rtl/fir_mac_engine.sv
// Consumes one queue read-out burst, accumulates sample*coefficient products and
// emits one rounded, saturated filtered sample per well-formed primed burst.
module fir_mac_engine
    import fir_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    fir_mac_engine_if.slave  bus
);

    localparam logic [ADDR_W-1:0] TAPS_A = ADDR_W'(NUM_TAPS);

    state_t                          state;
    state_t                          state_next;
    logic [ADDR_W-1:0]               tap_cnt;
    logic signed [ACC_W-1:0]         acc;
    logic                            seq_d1;
    logic                            primed;
    logic                            overlong;
    logic signed [DATA_W-1:0]        smpl_out_q;
    logic                            smpl_valid_q;
    logic                            len_err_q;
    logic                            seq_err_q;
    logic signed [DATA_W+COEFF_W-1:0] prod;
    logic signed [DATA_W-1:0]        sat_val;

    logic start;
    logic mac_en;
    logic cnt_inc;
    logic set_ovl;
    logic set_len;
    logic set_seq;
    logic load_out;

    assign prod = bus.smpl_in * bus.coeff;

    fir_round_sat u_round_sat (
        .acc     (acc),
        .sat_out (sat_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        mac_en     = 1'b0;
        cnt_inc    = 1'b0;
        set_ovl    = 1'b0;
        set_len    = 1'b0;
        set_seq    = 1'b0;
        load_out   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.sequencing) begin
                    start      = 1'b1;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                mac_en = seq_d1;
                if (bus.sequencing) begin
                    if (tap_cnt == TAPS_A) begin
                        set_ovl = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                state_next = IDLE;
                set_seq    = bus.sequencing;
                if (primed && (tap_cnt == TAPS_A) && !overlong) begin
                    load_out = 1'b1;
                end else if ((tap_cnt != TAPS_A) || overlong) begin
                    set_len = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tap_cnt and acc are cleared on the way out of OUTPUT so that a burst
    // starting in the very first IDLE cycle addresses coefficient 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt      <= '0;
            acc          <= '0;
            seq_d1       <= 1'b0;
            primed       <= 1'b0;
            overlong     <= 1'b0;
            smpl_out_q   <= '0;
            smpl_valid_q <= 1'b0;
            len_err_q    <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            seq_d1       <= bus.sequencing;
            smpl_valid_q <= load_out;
            if (state == ACCUM) begin
                if (mac_en) begin
                    acc <= acc + ACC_W'(prod);
                end
                if (cnt_inc) begin
                    tap_cnt <= tap_cnt + 1'b1;
                end
                if (set_ovl) begin
                    overlong <= 1'b1;
                end
            end else begin
                acc      <= '0;
                overlong <= 1'b0;
                tap_cnt  <= start ? ADDR_W'(1) : '0;
            end
            if (start) begin
                primed <= bus.q_full;
            end
            if (set_ovl || set_len) begin
                len_err_q <= 1'b1;
            end
            if (set_seq) begin
                seq_err_q <= 1'b1;
            end
            if (load_out) begin
                smpl_out_q <= sat_val;
            end
        end
    end

    assign bus.coeff_addr = tap_cnt;
    assign bus.smpl_out   = smpl_out_q;
    assign bus.smpl_valid = smpl_valid_q;
    assign bus.len_err    = len_err_q;
    assign bus.seq_err    = seq_err_q;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine: queue/ROM models feed bursts, a scoreboard
// holds the modelled filter outputs and is drained on every smpl_valid pulse.
module tb_fir_mac_engine;
    import fir_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    fir_mac_engine_if q ();

    fir_mac_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (q.slave)
    );

    always #5 clk = ~clk;

    logic signed [DATA_W-1:0]  smpl_mem  [2048];
    logic signed [COEFF_W-1:0] coeff_mem [1024];
    int seq_idx    = 0;
    int check_cnt  = 0;
    int pass_cnt   = 0;
    int fail_cnt   = 0;
    int valid_cnt  = 0;
    int exp_pulses = 0;
    logic signed [63:0] sb [$];
    logic signed [63:0] held_out = 0;

    // Queue returns the addressed sample, ROM the addressed coefficient, one cycle later.
    always @(posedge clk) begin
        if (q.sequencing) begin
            q.smpl_in <= smpl_mem[seq_idx[10:0]];
        end
        q.coeff <= coeff_mem[q.coeff_addr];
    end

    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.smpl_valid === 1'b1) begin
            valid_cnt++;
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected_valid", q.smpl_valid, 0);
            end else begin
                checkOutput("sb_smpl_out", q.smpl_out, sb.pop_front());
            end
        end
    end

    function automatic logic signed [63:0] modelOut(input int n);
        longint acc = 0;
        for (int k = 0; k < n; k++) begin
            acc += longint'(smpl_mem[k]) * longint'(coeff_mem[k]);
        end
        acc = (acc + 64'sd16384) >>> 15;
        if (acc > 32767) return 32767;
        if (acc < -32768) return -32768;
        return acc;
    endfunction

    task automatic setData(input int sval, input int cval);
        for (int k = 0; k < 2048; k++) smpl_mem[k] = DATA_W'(sval);
        for (int k = 0; k < 1024; k++) coeff_mem[k] = COEFF_W'(cval);
    endtask

    task automatic setRandom();
        for (int k = 0; k < 2048; k++) smpl_mem[k] = DATA_W'(int'($urandom_range(0, 4000)) - 2000);
        for (int k = 0; k < 1024; k++) coeff_mem[k] = COEFF_W'(int'($urandom_range(0, 4000)) - 2000);
    endtask

    // Drives one burst; rst_at >= 0 pulses reset before that tap, seq_in_out
    // raises sequencing during the OUTPUT cycle.
    task automatic applyStimulus(input int ntaps, input bit qf, input int rst_at,
                                 input bit seq_in_out, input string tag);
        int addr_bad = 0;
        int base = 0;
        int ea;
        bit exp_valid;
        logic signed [63:0] exp_out = 0;
        exp_valid = qf && (ntaps == NUM_TAPS) && (rst_at < 0);
        if (exp_valid) begin
            exp_out = modelOut(ntaps);
            sb.push_back(exp_out);
            exp_pulses++;
        end
        for (int k = 0; k < ntaps; k++) begin
            @(negedge clk);
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                checkOutput({tag, "_rst_smpl_out"}, q.smpl_out, 0);
                checkOutput({tag, "_rst_valid"}, q.smpl_valid, 0);
                checkOutput({tag, "_rst_len_err"}, q.len_err, 0);
                checkOutput({tag, "_rst_seq_err"}, q.seq_err, 0);
                held_out = 0;
                rst_n = 1'b1;
                base = k;
            end
            q.sequencing = 1'b1;
            q.q_full     = qf;
            seq_idx      = k;
            ea = (k - base > NUM_TAPS) ? NUM_TAPS : k - base;
            if (q.coeff_addr !== ADDR_W'(ea)) addr_bad++;
        end
        @(negedge clk);
        q.sequencing = 1'b0;
        checkOutput({tag, "_coeff_addr_errs"}, addr_bad, 0);
        @(negedge clk);
        checkOutput({tag, "_valid_n1"}, q.smpl_valid, 0);
        if (seq_in_out) q.sequencing = 1'b1;
        @(negedge clk);
        q.sequencing = 1'b0;
        if (exp_valid) held_out = exp_out;
        checkOutput({tag, "_valid_n2"}, q.smpl_valid, exp_valid);
        checkOutput({tag, "_smpl_out"}, q.smpl_out, held_out);
        @(negedge clk);
        checkOutput({tag, "_valid_n3"}, q.smpl_valid, 0);
    endtask

    initial begin
        q.sequencing = 1'b0;
        q.q_full     = 1'b0;
        setData(0, 0);
        #2 rst_n = 1'b0;
        #10;
        checkOutput("reset_smpl_out", q.smpl_out, 0);
        checkOutput("reset_valid", q.smpl_valid, 0);
        checkOutput("reset_len_err", q.len_err, 0);
        checkOutput("reset_seq_err", q.seq_err, 0);
        checkOutput("reset_coeff_addr", q.coeff_addr, 0);
        rst_n = 1'b1;

        $display("[TB] impulse and DC bursts");
        setData(0, 16384);
        smpl_mem[0] = 16'sd32767;
        applyStimulus(NUM_TAPS, 1'b1, -1, 1'b0, "impulse");
        checkOutput("impulse_value", q.smpl_out, 16384);
        checkOutput("impulse_len_err", q.len_err, 0);
        setData(10, 16384);
        applyStimulus(NUM_TAPS, 1'b1, -1, 1'b0, "dc10");
        checkOutput("dc10_value", q.smpl_out, 5105);
        setData(32767, 32767);
        applyStimulus(NUM_TAPS, 1'b1, -1, 1'b0, "dc_pos_sat");
        checkOutput("dc_pos_sat_value", q.smpl_out, 32767);
        setData(-32768, 32767);
        applyStimulus(NUM_TAPS, 1'b1, -1, 1'b0, "dc_neg_sat");
        checkOutput("dc_neg_sat_value", q.smpl_out, -32768);

        $display("[TB] unprimed burst");
        setData(5, 5);
        applyStimulus(NUM_TAPS, 1'b0, -1, 1'b0, "unprimed");
        checkOutput("unprimed_held", q.smpl_out, -32768);
        checkOutput("unprimed_len_err", q.len_err, 0);

        $display("[TB] back-to-back random bursts");
        setRandom();
        applyStimulus(NUM_TAPS, 1'b1, -1, 1'b0, "rand_a");
        @(negedge clk);
        setRandom();
        applyStimulus(NUM_TAPS, 1'b1, -1, 1'b0, "rand_b");
        checkOutput("rand_len_err", q.len_err, 0);
        checkOutput("rand_seq_err", q.seq_err, 0);

        $display("[TB] length errors");
        setData(3, 3);
        applyStimulus(1000, 1'b1, -1, 1'b0, "short");
        checkOutput("short_len_err", q.len_err, 1);
        applyStimulus(1025, 1'b1, -1, 1'b0, "long");
        checkOutput("long_len_err", q.len_err, 1);
        setData(7, 1000);
        applyStimulus(NUM_TAPS, 1'b1, -1, 1'b0, "after_err");
        checkOutput("after_err_len_err", q.len_err, 1);

        $display("[TB] reset mid-burst");
        setData(-9, 2000);
        applyStimulus(NUM_TAPS, 1'b1, 500, 1'b0, "rst_mid");
        checkOutput("rst_mid_len_err", q.len_err, 1);
        setRandom();
        applyStimulus(NUM_TAPS, 1'b1, -1, 1'b0, "after_rst");

        $display("[TB] sequencing during OUTPUT");
        checkOutput("pre_seq_err", q.seq_err, 0);
        setRandom();
        applyStimulus(NUM_TAPS, 1'b1, -1, 1'b1, "seq_out");
        checkOutput("seq_out_seq_err", q.seq_err, 1);

        repeat (4) @(negedge clk);
        checkOutput("sb_drained", sb.size(), 0);
        checkOutput("valid_pulse_count", valid_cnt, exp_pulses);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
